// File: rtl/shift_pkg.sv
// Shared types for the pipelined shifter: operation encoding and its width.
// Rotate support is selected by SHIFT_ROTATE_EN in shift_level and shift_unit_pipe.
package shift_pkg;

  typedef enum logic [1:0] {
    SHOP_SLL = 2'b00,
    SHOP_SRL = 2'b01,
    SHOP_SRA = 2'b10,
    SHOP_ROL = 2'b11
  } shop_t;

  localparam int SHOP_W = 2;

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: shifts by DIST when en is set.
// SHIFT_ROTATE_EN adds the rotate path; without it ROL behaves as SLL.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  shop_t            op,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = data;
    if (en) begin
      case (op)
        // fill is already 0 for SRL and the operand's original sign for SRA
        SHOP_SRL, SHOP_SRA: shifted = {{DIST{fill}}, data[WIDTH-1:DIST]};
`ifdef SHIFT_ROTATE_EN
        SHOP_ROL:           shifted = {data[WIDTH-1-DIST:0], data[WIDTH-1 -: DIST]};
`endif
        default:            shifted = {data[WIDTH-1-DIST:0], {DIST{1'b0}}};
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, ROL with SHIFT_ROTATE_EN) with valid/ready
// on both sides and a tag carried alongside each op.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4,
  localparam int SHAMT_W    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  shop_t              in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Handshake: a transfer occurs on a rising edge where valid & ready are both 1.
  // A stage loads when it is empty or its content moves on in the same cycle;
  // in_ready depends only on stage occupancy, out_ready and flush.

  localparam int N   = PIPE_STAGES;
  localparam int LVL = $clog2(WIDTH);
  localparam int C   = (LVL + N - 1) / N;

  logic [N-1:0]       v_q;
  logic [WIDTH-1:0]   d_q    [N];
  shop_t              op_q   [N];
  logic [SHAMT_W-1:0] sh_q   [N];
  logic               sign_q [N];
  logic [TAG_W-1:0]   tag_q  [N];

  logic [N-1:0]       s_v;
  logic [WIDTH-1:0]   s_d    [N];
  shop_t              s_op   [N];
  logic [SHAMT_W-1:0] s_sh   [N];
  logic               s_sign [N];
  logic [TAG_W-1:0]   s_tag  [N];
  logic [WIDTH-1:0]   raw    [N];
  logic [WIDTH-1:0]   nxt_d  [N];
  logic [WIDTH-1:0]   fin_d;
  logic [N-1:0]       load;

  logic [WIDTH-1:0]   lvl_in  [LVL];
  logic [WIDTH-1:0]   lvl_out [LVL];

  // Stage inputs: stage 0 sees the port, later stages see the previous register.
  always_comb begin
    s_v[0]    = in_valid;
    s_d[0]    = in_data;
    s_op[0]   = in_op;
    s_sh[0]   = in_shamt;
    s_sign[0] = in_data[WIDTH-1];
    s_tag[0]  = in_tag;
    for (int s = 1; s < N; s++) begin
      s_v[s]    = v_q[s-1];
      s_d[s]    = d_q[s-1];
      s_op[s]   = op_q[s-1];
      s_sh[s]   = sh_q[s-1];
      s_sign[s] = sign_q[s-1];
      s_tag[s]  = tag_q[s-1];
    end
  end

  // Stage s can load if out_ready or any stage from s to the last is empty.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      load[s] = out_ready;
      for (int j = s; j < N; j++) begin
        if (!v_q[j]) load[s] = 1'b1;
      end
    end
  end

  assign in_ready = load[0] & ~flush;

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int S = k / C;
    logic fill;
    assign fill = (s_op[S] == SHOP_SRA) & s_sign[S];
    if (k % C == 0) begin : g_first
      assign lvl_in[k] = s_d[S];
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end
    shift_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_level (
      .data    (lvl_in[k]),
      .en      (s_sh[S][k]),
      .op      (s_op[S]),
      .fill    (fill),
      .shifted (lvl_out[k])
    );
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int LO = s * C;
    localparam int HI = ((s + 1) * C < LVL) ? (s + 1) * C : LVL;
    if (HI > LO) begin : g_levels
      assign raw[s] = lvl_out[HI-1];
    end else begin : g_pass
      assign raw[s] = s_d[s];
    end
  end

  // Over-range amounts are resolved once, on the way into the last register.
  always_comb begin
    fin_d = raw[N-1];
    if (s_sh[N-1][SHAMT_W-1]) begin
      case (s_op[N-1])
        SHOP_SRA: fin_d = {WIDTH{s_sign[N-1]}};
`ifdef SHIFT_ROTATE_EN
        SHOP_ROL: fin_d = raw[N-1];
`endif
        default:  fin_d = '0;
      endcase
    end
  end

  always_comb begin
    for (int s = 0; s < N; s++) nxt_d[s] = raw[s];
    nxt_d[N-1] = fin_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < N; s++) begin
        d_q[s]    <= '0;
        op_q[s]   <= SHOP_SLL;
        sh_q[s]   <= '0;
        sign_q[s] <= 1'b0;
        tag_q[s]  <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else begin
      for (int s = 0; s < N; s++) begin
        if (load[s]) begin
          v_q[s] <= s_v[s];
          // Payload only moves with a valid op so a bubble never disturbs held data.
          if (s_v[s]) begin
            d_q[s]    <= nxt_d[s];
            op_q[s]   <= s_op[s];
            sh_q[s]   <= s_sh[s];
            sign_q[s] <= s_sign[s];
            tag_q[s]  <= s_tag[s];
          end
        end
      end
    end
  end

  assign out_valid = v_q[N-1];
  assign out_data  = d_q[N-1];
  assign out_tag   = tag_q[N-1];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe (WIDTH=16, PIPE_STAGES=2); ROL expectations
// follow SHIFT_ROTATE_EN.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  shop_t       in_op;
  logic [15:0] in_data;
  logic [4:0]  in_shamt;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];

  shift_unit_pipe #(.WIDTH(16), .PIPE_STAGES(2), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input shop_t op, input logic [15:0] d, input logic [4:0] sh,
                       input logic [3:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    in_tag   = t;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Starts and ends just after a rising edge; checks the two-cycle latency.
  task automatic run_op(input string name, input shop_t op, input logic [15:0] d,
                        input logic [4:0] sh, input logic [3:0] t, input logic [15:0] exp);
    drive(op, d, sh, t);
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk({name, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(exp));
    chk({name, "_tag"}, 32'(out_tag), 32'(t));
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    int got;
    int next_t;
    logic [19:0] e;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_op = SHOP_SLL; in_data = '0; in_shamt = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_op("sll1", SHOP_SLL, 16'h8001, 5'd1, 4'd5, 16'h0002);
    run_op("sra15", SHOP_SRA, 16'h8000, 5'd15, 4'd6, 16'hFFFF);
    run_op("sra16", SHOP_SRA, 16'h8000, 5'd16, 4'd7, 16'hFFFF);
    run_op("srl16", SHOP_SRL, 16'h8000, 5'd16, 4'd8, 16'h0000);
    run_op("srl4", SHOP_SRL, 16'h00F0, 5'd4, 4'd9, 16'h000F);
    run_op("sra_pos", SHOP_SRA, 16'h7FF0, 5'd4, 4'd10, 16'h07FF);
    run_op("sra_neg", SHOP_SRA, 16'h8F00, 5'd4, 4'd11, 16'hF8F0);
    run_op("sll16", SHOP_SLL, 16'hFFFF, 5'd16, 4'd12, 16'h0000);
    run_op("sll9", SHOP_SLL, 16'h00FF, 5'd9, 4'd13, 16'hFE00);
`ifdef SHIFT_ROTATE_EN
    run_op("rol4", SHOP_ROL, 16'h8001, 5'd4, 4'd14, 16'h0018);
    run_op("rol20", SHOP_ROL, 16'h8001, 5'd20, 4'd15, 16'h0018);
`else
    run_op("rol4", SHOP_ROL, 16'h8001, 5'd4, 4'd14, 16'h0010);
    run_op("rol20", SHOP_ROL, 16'h8001, 5'd20, 4'd15, 16'h0000);
`endif

    // Stall: op t is SRL by 4 of (t << 8), so result is t << 4.
    out_ready = 1'b0;
    drive(SHOP_SRL, 16'h0100, 5'd4, 4'd1);
    @(negedge clk);
    chk("stall_acc1", 32'(in_ready), 32'd1);
    exp_q.push_back({4'd1, 16'h0010});
    @(posedge clk); #1;
    drive(SHOP_SRL, 16'h0200, 5'd4, 4'd2);
    @(negedge clk);
    chk("stall_acc2", 32'(in_ready), 32'd1);
    exp_q.push_back({4'd2, 16'h0020});
    @(posedge clk); #1;
    drive(SHOP_SRL, 16'h0300, 5'd4, 4'd3);
    @(negedge clk);
    chk("stall_full", 32'(in_ready), 32'd0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_tag", 32'(out_tag), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_full2", 32'(in_ready), 32'd0);
    chk("stall_hold_data", 32'(out_data), 32'h0010);
    chk("stall_hold_tag", 32'(out_tag), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 0;
    next_t = 3;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stall_extra_out", 32'(out_tag), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stall_order", {12'd0, out_tag, out_data}, {12'd0, e});
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, 16'(in_tag) << 4});
        next_t++;
      end
      @(posedge clk); #1;
      if (next_t <= 4) drive(SHOP_SRL, 16'(next_t) << 8, 5'd4, 4'(next_t));
      else idle();
    end
    idle();
    chk("stall_count", 32'(got), 32'd4);
    chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with two ops in flight.
    drive(SHOP_SLL, 16'h0001, 5'd1, 4'd1);
    @(posedge clk); #1;
    drive(SHOP_SLL, 16'h0001, 5'd2, 4'd2);
    @(posedge clk); #1;
    idle();
    #2;
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("arst_no_out", 32'(cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Flush with two ops in flight and a new op offered.
    drive(SHOP_SRL, 16'hF000, 5'd4, 4'd3);
    @(posedge clk); #1;
    drive(SHOP_SRL, 16'hF000, 5'd8, 4'd4);
    @(posedge clk); #1;
    drive(SHOP_SRL, 16'hF000, 5'd12, 4'd5);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("flush_no_out", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    run_op("post_flush", SHOP_SRA, 16'hC000, 5'd2, 4'd6, 16'hF000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
